// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into HOLD_CYCLES-high bursts separated by GAP_CYCLES low,
// queuing pulses that arrive mid-burst in a saturating pending counter.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear_overflow,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int CNT_MAX = ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0]     HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;
    logic              expire;
    logic              drop;

    // The GAP-expiry edge either consumes a pulse (queued or live) or returns to IDLE.
    assign expire = (state_q == GAP) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if ((pend_q != '0) || pulse_in) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        drop   = 1'b0;
        if (state_q != IDLE) begin
            if (expire) begin
                if ((pend_q != '0) && !pulse_in) begin
                    pend_d = pend_q - 1'b1;
                end
            end else if (pulse_in) begin
                if (pend_q == PEND_MAX) begin
                    drop = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
        end
        ovf_d = ovf_q;
        if (clear_overflow) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        level_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a cycle model queues expected outputs per driven step,
// popped and compared after each edge, plus burst-shape totals checked against fixed numbers.
module tb_pulse_stretcher;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PW = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          pulse_in = 1'b0;
    logic          clear_overflow = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
        .clock(clock), .reset(reset), .pulse_in(pulse_in), .clear_overflow(clear_overflow),
        .level_out(level_out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          lvl;
        logic          bsy;
        logic [PW-1:0] pnd;
        logic          ovf;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase plus cycles remaining in that phase.
    int m_ph = 0;      // 0 idle, 1 hold, 2 gap
    int m_left = 0;
    int m_pend = 0;
    bit m_ovf = 0;

    // Observed burst-shape statistics.
    int hi_cycles, busy_cycles, rises;
    logic prev_lvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit p, input bit c);
        bit drop;
        drop = 0;
        if (r) begin
            m_ph = 0; m_left = 0; m_pend = 0; m_ovf = 0;
            return;
        end
        if (m_ph == 2 && m_left == 1) begin
            if (m_pend > 0 || p) begin
                if (m_pend > 0 && !p) m_pend--;
                m_ph = 1; m_left = H;
            end else begin
                m_ph = 0;
            end
        end else begin
            if (m_ph != 0 && p) begin
                if (m_pend == PMAX) drop = 1; else m_pend++;
            end
            case (m_ph)
                0: if (p) begin m_ph = 1; m_left = H; end
                1: if (m_left == 1) begin m_ph = 2; m_left = G; end else m_left--;
                default: m_left--;
            endcase
        end
        if (c) m_ovf = 0;
        if (drop) m_ovf = 1;
    endtask

    task automatic step(input bit r, input bit p, input bit c);
        exp_t e, got;
        reset = r; pulse_in = p; clear_overflow = c;
        model(r, p, c);
        e.lvl = (m_ph == 1);
        e.bsy = (m_ph != 0);
        e.pnd = PW'(m_pend);
        e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk("level_out", {31'd0, level_out}, {31'd0, got.lvl});
        chk("busy", {31'd0, busy}, {31'd0, got.bsy});
        chk("pending", {30'd0, pending}, {30'd0, got.pnd});
        chk("overflow", {31'd0, overflow}, {31'd0, got.ovf});
        if (level_out === 1'b1) hi_cycles++;
        if (busy === 1'b1) busy_cycles++;
        if (level_out === 1'b1 && prev_lvl !== 1'b1) rises++;
        prev_lvl = level_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic clr_stats();
        hi_cycles = 0; busy_cycles = 0; rises = 0; prev_lvl = level_out;
    endtask

    initial begin
        @(negedge clock);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Single pulse: 4 high, 6 busy, back to idle.
        clr_stats();
        step(0, 1, 0);
        idle(8);
        chk("single_hi", hi_cycles, H);
        chk("single_busy", busy_cycles, H + G);
        chk("single_rises", rises, 1);

        // Pulses at t0 and t2: two bursts.
        clr_stats();
        step(0, 1, 0); step(0, 0, 0); step(0, 1, 0);
        chk("two_pend", {30'd0, pending}, 32'd1);
        idle(12);
        chk("two_hi", hi_cycles, 2 * H);
        chk("two_busy", busy_cycles, 2 * H + 2 * G);

        // Five consecutive pulses: overflow and 4 bursts.
        clr_stats();
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("burst5_ovf", {31'd0, overflow}, 32'd1);
        idle(30);
        chk("burst5_rises", rises, 4);
        chk("burst5_ovf_sticky", {31'd0, overflow}, 32'd1);
        step(0, 0, 1);
        chk("burst5_cleared", {31'd0, overflow}, 32'd0);

        // Pulse on GAP-expiry edge with nothing pending: busy never drops.
        clr_stats();
        step(0, 1, 0);
        idle(H + G - 1);
        step(0, 1, 0);
        chk("expiry_busy", {31'd0, busy}, 32'd1);
        idle(H + G + 2);
        chk("expiry_busy_total", busy_cycles, 2 * (H + G));
        chk("expiry_rises", rises, 2);

        // Reset mid-burst with pending=2, then a clean burst.
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        chk("rst_pre_pend", {30'd0, pending}, 32'd2);
        step(1, 0, 0);
        step(0, 0, 0);
        clr_stats();
        step(0, 1, 0);
        idle(8);
        chk("post_rst_hi", hi_cycles, H);

        // Drop and clear on the same edge: set wins.
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(0, 1, 1);
        chk("set_wins", {31'd0, overflow}, 32'd1);
        idle(3);
        step(0, 0, 1);
        chk("clear_later", {31'd0, overflow}, 32'd0);
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
